// File: rtl/adc_ctrl_pkg.sv
// Shared types for the ADC threshold controller: FSM state encoding and channel-index width helper.
package adc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Channel index width; a single-channel build still carries a 1-bit index.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_threshold_ctrl_if.sv
// Request, result and SPI signals of the ADC threshold controller.
// master = controller side, slave = requester / ADC side.
interface adc_threshold_ctrl_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned NUM_CH = 4
);
  import adc_ctrl_pkg::*;

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic              start;
  logic              scan;
  logic [CH_W-1:0]   ch_sel;
  logic [DATA_W-1:0] threshold;
  logic              miso;
  logic              cs_n;
  logic              sck;
  logic              mosi;
  logic              busy;
  logic              res_valid;
  logic [CH_W-1:0]   res_ch;
  logic [DATA_W-1:0] sample;
  logic              above;
  logic [NUM_CH-1:0] above_mask;
  logic              done;

  modport master (
    input  start, scan, ch_sel, threshold, miso,
    output cs_n, sck, mosi, busy, res_valid, res_ch, sample, above, above_mask, done
  );

  modport slave (
    output start, scan, ch_sel, threshold, miso,
    input  cs_n, sck, mosi, busy, res_valid, res_ch, sample, above, above_mask, done
  );

endinterface

// File: rtl/adc_sck_gen.sv
// SCK divider: CLK_DIV-cycle tick counter, SPI clock toggle and rise/fall strobes.
module adc_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_sck_en,
  output logic o_sck,
  output logic o_tick_c,
  output logic o_rise_c,
  output logic o_fall_c
);
  localparam int unsigned DIV_W = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);

  logic [DIV_W-1:0] r_div;
  logic             r_sck;

  assign o_tick_c = i_run && (r_div == DIV_W'(CLK_DIV - 1));
  assign o_rise_c = o_tick_c && i_sck_en && !r_sck;
  assign o_fall_c = o_tick_c && i_sck_en && r_sck;
  assign o_sck    = r_sck;

  // Counter restarts from zero each time the controller leaves IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (!i_run) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else begin
      r_div <= o_tick_c ? '0 : r_div + DIV_W'(1);
      if (o_tick_c && i_sck_en) r_sck <= ~r_sck;
    end
  end

endmodule

// File: rtl/adc_threshold_ctrl.sv
// ADC threshold controller: reads one or all channels of an SPI ADC and flags samples above a threshold.
// Define ADC_HYST_EN to compare against a per-channel +/-HYST hysteresis band instead.
module adc_threshold_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned CLK_DIV = 4
`ifdef ADC_HYST_EN
  ,
  parameter int unsigned HYST    = 8
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  adc_threshold_ctrl_if.master bus
);
  localparam int unsigned CH_W  = ch_width(NUM_CH);
  localparam int unsigned BIT_W = $clog2(FRAME_W);

  state_e            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt;
  logic [CH_W-1:0]   r_addr, w_addr_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic              w_latch, w_commit, w_done_nxt;
  logic              w_sck, w_tick, w_rise, w_fall;

  logic              r_scan;
  logic [DATA_W-1:0] r_thr;
  logic [DATA_W-1:0] r_shift;
  logic              r_cs_n, r_busy, r_res_valid, r_done, r_above;
  logic [CH_W-1:0]   r_res_ch;
  logic [DATA_W-1:0] r_sample;
  logic [NUM_CH-1:0] r_above_mask, w_mask_nxt;
  logic              w_above;

  adc_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (r_state != ST_IDLE),
    .i_sck_en (r_state == ST_SHIFT),
    .o_sck    (w_sck),
    .o_tick_c (w_tick),
    .o_rise_c (w_rise),
    .o_fall_c (w_fall)
  );

  // Next-state: every state change lands on a divider tick, SHIFT ends on its last SCK fall.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_addr_nxt  = r_addr;
    w_bit_nxt   = r_bit;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_SETUP;
          w_ch_nxt    = bus.scan ? '0 : bus.ch_sel;
          w_addr_nxt  = bus.scan ? '0 : bus.ch_sel;
          w_bit_nxt   = '0;
        end
      end
      ST_SETUP: begin
        if (w_tick) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_fall) begin
          w_addr_nxt = r_addr << 1;
          w_bit_nxt  = r_bit + BIT_W'(1);
          if (r_bit == BIT_W'(FRAME_W - 1)) w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_tick) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (w_tick) begin
          w_commit = 1'b1;
          if (r_scan && (r_ch < CH_W'(NUM_CH - 1))) begin
            w_state_nxt = ST_SETUP;
            w_ch_nxt    = r_ch + CH_W'(1);
            w_addr_nxt  = r_ch + CH_W'(1);
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_addr  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_addr  <= w_addr_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

`ifdef ADC_HYST_EN
  logic [DATA_W:0]   w_hi_sum;
  logic [DATA_W-1:0] w_hi, w_lo;
  logic              w_prev;

  // Band edges saturate so threshold near 0 or full scale never wraps.
  assign w_hi_sum = (DATA_W+1)'(r_thr) + (DATA_W+1)'(HYST);
  assign w_hi     = w_hi_sum[DATA_W] ? '1 : w_hi_sum[DATA_W-1:0];
  assign w_lo     = (r_thr > DATA_W'(HYST)) ? (r_thr - DATA_W'(HYST)) : '0;
  assign w_prev   = |(r_above_mask & (NUM_CH'(1) << r_ch));
  assign w_above  = (r_shift > w_hi) ? 1'b1 : ((r_shift < w_lo) ? 1'b0 : w_prev);
`else
  assign w_above  = (r_shift > r_thr);
`endif

  always_comb begin
    w_mask_nxt = r_above_mask;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (CH_W'(i) == r_ch) w_mask_nxt[i] = w_above;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan       <= 1'b0;
      r_thr        <= '0;
      r_shift      <= '0;
      r_cs_n       <= 1'b1;
      r_busy       <= 1'b0;
      r_res_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_res_ch     <= '0;
      r_sample     <= '0;
      r_above      <= 1'b0;
      r_above_mask <= '0;
    end else begin
      r_cs_n      <= !(w_state_nxt inside {ST_SETUP, ST_SHIFT, ST_HOLD});
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_res_valid <= w_commit;
      r_done      <= w_done_nxt;
      if (w_latch) begin
        r_scan <= bus.scan;
        r_thr  <= bus.threshold;
      end
      if (w_rise) r_shift <= DATA_W'({r_shift, bus.miso});
      if (w_commit) begin
        r_res_ch     <= r_ch;
        r_sample     <= r_shift;
        r_above      <= w_above;
        r_above_mask <= w_mask_nxt;
      end
    end
  end

  assign bus.cs_n       = r_cs_n;
  assign bus.sck        = w_sck;
  assign bus.mosi       = r_addr[CH_W-1];
  assign bus.busy       = r_busy;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_ch     = r_res_ch;
  assign bus.sample     = r_sample;
  assign bus.above      = r_above;
  assign bus.above_mask = r_above_mask;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_adc_threshold_ctrl.sv
// Self-checking bench for adc_threshold_ctrl with a behavioural SPI ADC model.
// Also builds with ADC_HYST_EN defined.
module tb_adc_threshold_ctrl;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CH_W    = 2;
  localparam int FRAME_CYC = CLK_DIV * (2 * FRAME_W + 3);
  localparam int LEAD_BITS = FRAME_W - DATA_W;
`ifdef ADC_HYST_EN
  localparam int HYST = 8;
`endif

  typedef struct {
    int                cyc;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] smp;
    logic              ab;
    logic [NUM_CH-1:0] mask;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  adc_threshold_ctrl_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  adc_threshold_ctrl #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .FRAME_W(FRAME_W), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ADC model: shifts junk lead bits then the addressed channel's sample, MSB first.
  logic [DATA_W-1:0]  adc_tab [NUM_CH];
  logic [FRAME_W-1:0] mosi_q [$];
  logic [FRAME_W-1:0] rx_word;
  logic [FRAME_W-1:0] junk;
  logic [CH_W-1:0]    rx_addr;
  int                 rx_cnt;
  int                 bit_idx;
  logic               prev_cs_n = 1'b1;
  logic               prev_sck = 1'b0;
  bit                 exp_mask [NUM_CH];

  function automatic logic adc_bit(input int idx);
    logic [DATA_W-1:0] w;
    if (idx < LEAD_BITS) return junk[idx];
    w = adc_tab[rx_addr];
    return w[DATA_W-1-(idx-LEAD_BITS)];
  endfunction

  always @(negedge clk) begin
    if (!rst_n || bus.cs_n !== 1'b0) begin
      if (rst_n && !prev_cs_n) mosi_q.push_back(rx_word);
      bus.miso = 1'b0;
      bit_idx  = 0;
      prev_cs_n = 1'b1;
    end else begin
      if (prev_cs_n) begin
        bit_idx = 0; rx_cnt = 0; rx_word = '0; rx_addr = '0;
        junk = FRAME_W'($urandom);
      end else if (prev_sck && !bus.sck) begin
        bit_idx++;
      end else if (!prev_sck && bus.sck) begin
        rx_word = {rx_word[FRAME_W-2:0], bus.mosi};
        if (rx_cnt < int'(CH_W)) rx_addr = {rx_addr[CH_W-2:0], bus.mosi};
        rx_cnt++;
      end
      bus.miso = adc_bit(bit_idx);
      prev_cs_n = 1'b0;
    end
    prev_sck = (bus.sck === 1'b1);
  end

  task automatic test_request(input string name, input logic sc, input logic [CH_W-1:0] ch,
                              input logic [DATA_W-1:0] thr, input int repulse_at);
    int   chans [$];
    ev_t  evs [$];
    int   nfr, done_at, busy_drop, s, t, c, lim;
    logic a;
    logic [NUM_CH-1:0] m;
    mosi_q.delete();
    if (sc) for (int i = 0; i < int'(NUM_CH); i++) chans.push_back(i);
    else chans.push_back(int'(ch));
    nfr = chans.size();
    done_at = -1;
    busy_drop = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.scan = sc; bus.ch_sel = ch; bus.threshold = thr;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.scan = 1'($urandom); bus.ch_sel = CH_W'($urandom); bus.threshold = DATA_W'($urandom);
    for (int n = 1; n <= nfr * FRAME_CYC + 20 && done_at < 0; n++) begin
      bus.start = (n == repulse_at);
      @(posedge clk); #1;
      if (bus.res_valid)
        evs.push_back('{n, bus.res_ch, bus.sample, bus.above, bus.above_mask});
      if (bus.done) done_at = n;
      else if (!bus.busy) busy_drop++;
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (evs.size() !== nfr) begin
      n_fail++; $display("FAIL %s res_valid count: got %0d exp %0d", name, evs.size(), nfr);
    end
    n_checks++;
    if (done_at !== nfr * FRAME_CYC) begin
      n_fail++; $display("FAIL %s done cycle: got %0d exp %0d", name, done_at, nfr * FRAME_CYC);
    end
    n_checks++;
    if (busy_drop !== 0) begin
      n_fail++; $display("FAIL %s busy low during request: got %0d cycles exp 0", name, busy_drop);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s idle after done: busy=%b cs_n=%b res_valid=%b exp 0/1/0",
                         name, bus.busy, bus.cs_n, bus.res_valid);
    end
    lim = (evs.size() < nfr) ? evs.size() : nfr;
    t = int'(thr);
    for (int k = 0; k < lim; k++) begin
      c = chans[k];
      s = int'(adc_tab[c]);
`ifdef ADC_HYST_EN
      if (s > t + HYST) a = 1'b1;
      else if (s < t - HYST) a = 1'b0;
      else a = exp_mask[c];
`else
      a = (s > t);
`endif
      exp_mask[c] = a;
      for (int i = 0; i < int'(NUM_CH); i++) m[i] = exp_mask[i];
      n_checks++;
      if (evs[k].cyc !== (k + 1) * FRAME_CYC) begin
        n_fail++; $display("FAIL %s res_valid[%0d] cycle: got %0d exp %0d", name, k, evs[k].cyc, (k + 1) * FRAME_CYC);
      end
      n_checks++;
      if (evs[k].ch !== CH_W'(c)) begin
        n_fail++; $display("FAIL %s res_ch[%0d]: got %0d exp %0d", name, k, evs[k].ch, c);
      end
      n_checks++;
      if (evs[k].smp !== DATA_W'(s)) begin
        n_fail++; $display("FAIL %s sample[%0d]: got %h exp %h", name, k, evs[k].smp, s);
      end
      n_checks++;
      if (evs[k].ab !== a) begin
        n_fail++; $display("FAIL %s above[%0d]: got %b exp %b", name, k, evs[k].ab, a);
      end
      n_checks++;
      if (evs[k].mask !== m) begin
        n_fail++; $display("FAIL %s above_mask[%0d]: got %b exp %b", name, k, evs[k].mask, m);
      end
      n_checks++;
      if (k >= mosi_q.size() || mosi_q[k] !== (FRAME_W'(c) << (FRAME_W - CH_W))) begin
        n_fail++; $display("FAIL %s mosi frame[%0d]: got %h exp %h", name, k,
                           (k < mosi_q.size()) ? mosi_q[k] : 'x, FRAME_W'(c) << (FRAME_W - CH_W));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.cs_n !== 1'b1 || bus.sck !== 1'b0 || bus.mosi !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset spi/busy: cs_n=%b sck=%b mosi=%b busy=%b exp 1/0/0/0",
                         bus.cs_n, bus.sck, bus.mosi, bus.busy);
    end
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.done !== 1'b0 || bus.above !== 1'b0) begin
      n_fail++; $display("FAIL reset pulses: res_valid=%b done=%b above=%b exp 0/0/0",
                         bus.res_valid, bus.done, bus.above);
    end
    n_checks++;
    if (bus.res_ch !== '0 || bus.sample !== '0 || bus.above_mask !== '0) begin
      n_fail++; $display("FAIL reset results: res_ch=%0d sample=%h mask=%b exp 0/0/0",
                         bus.res_ch, bus.sample, bus.above_mask);
    end
    for (int i = 0; i < int'(NUM_CH); i++) exp_mask[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_boundary();
    adc_tab[1] = 12'hFFF;
    test_request("full_scale", 1'b0, 2'd1, 12'hFFF, -1);
    adc_tab[1] = 12'h000;
    test_request("zero", 1'b0, 2'd1, 12'h000, -1);
  endtask

  task automatic test_single();
    for (int i = 0; i < int'(NUM_CH); i++) adc_tab[i] = DATA_W'($urandom);
    adc_tab[2] = 12'hA5C;
    test_request("single", 1'b0, 2'd2, 12'h800, -1);
  endtask

  task automatic test_scan();
    adc_tab[0] = 12'h100; adc_tab[1] = 12'h900; adc_tab[2] = 12'h7FF; adc_tab[3] = 12'h800;
    test_request("scan", 1'b1, 2'd0, 12'h7FF, -1);
  endtask

  task automatic test_start_ignored();
    adc_tab[3] = DATA_W'($urandom);
    test_request("start_busy", 1'b0, 2'd3, DATA_W'($urandom), 30);
  endtask

  task automatic test_hyst_seq();
    adc_tab[0] = 12'h409; test_request("band_a", 1'b0, 2'd0, 12'h400, -1);
    adc_tab[0] = 12'h3FC; test_request("band_b", 1'b0, 2'd0, 12'h400, -1);
    adc_tab[0] = 12'h3F7; test_request("band_c", 1'b0, 2'd0, 12'h400, -1);
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] thr;
    for (int r = 0; r < 6; r++) begin
      thr = DATA_W'($urandom);
      for (int i = 0; i < int'(NUM_CH); i++)
        adc_tab[i] = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom)
                                                 : DATA_W'(int'(thr) + $urandom_range(0, 24) - 12);
      test_request("random", 1'($urandom), CH_W'($urandom), thr, -1);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    adc_tab[0] = 12'hFFF; adc_tab[1] = 12'hFFF;
    @(negedge clk);
    bus.start = 1'b1; bus.scan = 1'b1; bus.threshold = 12'h001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n < 40; n++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.cs_n !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_frame before reset: cs_n=%b busy=%b exp 0/1", bus.cs_n, bus.busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.cs_n !== 1'b1 || bus.sck !== 1'b0 || bus.busy !== 1'b0 || bus.above_mask !== '0) begin
      n_fail++; $display("FAIL reset_abort: cs_n=%b sck=%b busy=%b mask=%b exp 1/0/0/0",
                         bus.cs_n, bus.sck, bus.busy, bus.above_mask);
    end
    for (int i = 0; i < int'(NUM_CH); i++) exp_mask[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 4 * FRAME_CYC; n++) begin
      @(posedge clk); #1;
      if (bus.res_valid || bus.done || bus.busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_abort activity after reset: got %0d cycles exp 0", seen);
    end
    adc_tab[1] = 12'h555;
    test_request("after_reset", 1'b0, 2'd1, 12'h554, -1);
  endtask

  initial begin
    bus.start = 1'b0; bus.scan = 1'b0; bus.ch_sel = '0; bus.threshold = '0;
    for (int i = 0; i < int'(NUM_CH); i++) adc_tab[i] = '0;
    test_reset();
    test_boundary();
    test_single();
    test_scan();
    test_start_ignored();
    test_hyst_seq();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_threshold_ctrl.md
ADC_THRESHOLD_CTRL -- requirements
Module: adc_threshold_ctrl

Interface
REQ-001 Parameter DATA_W, default 12: ADC sample width in bits.
REQ-002 Parameter NUM_CH, default 4: ADC channel count, range 1..8; CH_W = max(1, clog2(NUM_CH)).
REQ-003 Parameter FRAME_W, default 16: SCK cycles per SPI frame; FRAME_W >= CH_W + DATA_W.
REQ-004 Parameter CLK_DIV, default 4: SCK half-period in clk cycles; CLK_DIV >= 1.
REQ-005 Parameter HYST, default 8: hysteresis band in LSBs; used only under ADC_HYST_EN.
REQ-006 clk  in  1  single system clock; all logic rises on clk.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 start  in  1  conversion request; sampled only in IDLE.
REQ-009 scan  in  1  1 = convert channels 0..NUM_CH-1 in turn; 0 = convert ch_sel only.
REQ-010 ch_sel  in  CH_W  channel for single mode.
REQ-011 threshold  in  DATA_W  compare level.
REQ-012 miso  in  1  ADC serial data.
REQ-013 cs_n  out  1  ADC chip select, active low.
REQ-014 sck  out  1  SPI clock, mode 0 (idles low).
REQ-015 mosi  out  1  channel address to ADC.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 res_valid  out  1  one-cycle pulse per completed frame.
REQ-018 res_ch  out  CH_W  channel of current result.
REQ-019 sample  out  DATA_W  captured sample.
REQ-020 above  out  1  comparison result for res_ch.
REQ-021 above_mask  out  NUM_CH  latest above bit per channel.
REQ-022 done  out  1  one-cycle pulse at end of request.

Function
REQ-023 FSM states IDLE, SETUP, SHIFT, HOLD, GAP; one CLK_DIV-cycle dwell each in SETUP, HOLD, GAP; SHIFT lasts 2*CLK_DIV*FRAME_W cycles.
REQ-024 IDLE -> SETUP on start; scan, ch_sel, threshold latched on that edge; start while busy ignored.
REQ-025 SETUP: cs_n low, sck low, mosi = channel address MSB.
REQ-026 SHIFT: sck toggles every CLK_DIV cycles starting low; miso sampled on the clk edge driving sck 0->1; mosi updates on the edge driving sck 1->0.
REQ-027 mosi frame bit i = channel bit CH_W-1-i for i < CH_W, else 0.
REQ-028 sample = last DATA_W miso bits of frame, MSB first; earlier bits discarded.
REQ-029 HOLD: sck low, cs_n low; GAP: cs_n high.
REQ-030 End of GAP: res_valid, res_ch, sample, above updated together; above_mask[res_ch] written.
REQ-031 After GAP: next channel -> SETUP if scan and channel < NUM_CH-1; otherwise done pulses with the final res_valid, FSM -> IDLE.
REQ-032 Frame length exactly CLK_DIV*(2*FRAME_W+3) cycles; start edge to done = N_frames times that.
REQ-033 Comparison unsigned, full DATA_W width, no truncation.

Reset
REQ-034 rst_n low at a clk edge: FSM IDLE, cs_n 1, sck 0, mosi 0, busy 0, res_valid 0, done 0, res_ch 0, sample 0, above 0, above_mask 0.
REQ-035 Reset mid-frame aborts immediately; no res_valid or done for the aborted request.

Configuration
REQ-036 ADC_HYST_EN undefined: above = sample > threshold.
REQ-037 ADC_HYST_EN defined: above sets when sample > threshold+HYST, clears when sample < threshold-HYST, else keeps above_mask[res_ch]; saturating at 0 and 2^DATA_W-1.

Structure
REQ-038 Package adc_ctrl_pkg holds FSM state enum and CH_W helper function.
REQ-039 Sub-module adc_sck_gen holds the CLK_DIV counter, SCK toggle and rise/fall strobes.

Verification (DATA_W=12, NUM_CH=4, FRAME_W=16, CLK_DIV=2)
REQ-040 Single, ch_sel=2, ADC model returns 0xA5C, threshold 0x800 -> mosi 1,0 then 0s; sample 0xA5C, above 1, res_ch 2, done 70 cycles after start.
REQ-041 Scan, samples 0x100/0x900/0x7FF/0x800, threshold 0x7FF -> 4 res_valid 70 cycles apart; above_mask 4'b1010; done with 4th.
REQ-042 start pulsed again at cycle 30 of a frame -> ignored; single done.
REQ-043 rst_n low at cycle 40 of a scan -> cs_n 1, sck 0 next edge; above_mask 0; no done.
REQ-044 ADC_HYST_EN, HYST=8, threshold 0x400, samples 0x409, 0x3FC, 0x3F7 -> above 1, 1, 0.
REQ-045 threshold 0xFFF, sample 0xFFF -> above 0; threshold 0, sample 0 with ADC_HYST_EN -> no underflow, above stays 0.
